// File: rtl/ocra1_pkg.sv
// ---------------------------------------------------------------------------
// ocra1_pkg
// Shared definitions for the OCRA1 gradient-board SPI serialiser.
//   - OCRA1_* localparams : frame width and default timing parameters
//   - ocra1_state_e       : serialiser FSM states
//   - ocra1_frame_set_t   : one X/Y/Z/Z2 frame set plus its LDAC request
// ---------------------------------------------------------------------------
package ocra1_pkg;

  localparam int OCRA1_FRAME_BITS   = 24;
  localparam int OCRA1_DIV_WIDTH    = 6;
  localparam int OCRA1_LDAC_CYCLES  = 4;
  localparam int OCRA1_SYNC_HIGH_HP = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    SYNC_HIGH,
    LDAC
  } ocra1_state_e;

  // Field order matters: the top level packs the inputs as {x, y, z, z2, ldac}.
  typedef struct packed {
    logic [OCRA1_FRAME_BITS-1:0] x;
    logic [OCRA1_FRAME_BITS-1:0] y;
    logic [OCRA1_FRAME_BITS-1:0] z;
    logic [OCRA1_FRAME_BITS-1:0] z2;
    logic                        ldac;
  } ocra1_frame_set_t;

endpackage

// File: rtl/ocra1_tick_gen.sv
// ---------------------------------------------------------------------------
// ocra1_tick_gen
// Half-period tick generator for the OCRA1 SPI serialiser.
//   clk, rst : system clock, synchronous active-high reset
//   start_i  : restart the count and capture div_i for the whole frame set
//   div_i    : half-period length minus one, in clk cycles
//   tick_o   : high for one cycle at the end of every half-period
// After a start the first tick ends div_i+1 cycles later; the divider value
// is frozen until the next start so mid-frame changes have no effect.
// ---------------------------------------------------------------------------
module ocra1_tick_gen
  import ocra1_pkg::*;
#(
  parameter int DIV_WIDTH = OCRA1_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] count_q;

  // Down-counter that reloads from the frozen divider each time it expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      count_q <= '0;
    end else if (start_i) begin
      div_q   <= div_i;
      count_q <= div_i;
    end else if (count_q == '0) begin
      count_q <= div_q;
    end else begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tick_o = (count_q == '0);

endmodule

// File: rtl/ocra1_spi_serialiser.sv
// ---------------------------------------------------------------------------
// ocra1_spi_serialiser
// Shifts four 24-bit DAC frames (X, Y, Z, Z2) in parallel onto the OCRA1
// gradient-board SPI pins, with SYNCn framing and an optional LDACn pulse.
// One frame set can be queued behind the one being shifted.
//   clk, rst        : system clock, synchronous active-high reset
//   data_*_i        : channel frames, shifted MSB first
//   valid_i         : strobe that latches all four frames plus ldac_i
//   ldac_i          : pulse LDACn after this frame set
//   spi_div_i       : SCLK half-period = spi_div_i+1 clk cycles
//   overrun_clr_i   : clears overrun_o (a simultaneous overrun wins)
//   busy_o          : frame set shifting or pending
//   overrun_o       : sticky, a pending set was overwritten
//   ocra1_clk_o     : SCLK, idles low
//   ocra1_syncn_o   : SYNCn
//   ocra1_ldacn_o   : LDACn
//   ocra1_sdo*_o    : per-channel serial data
// ---------------------------------------------------------------------------
module ocra1_spi_serialiser
  import ocra1_pkg::*;
#(
  parameter int FRAME_BITS   = OCRA1_FRAME_BITS,
  parameter int DIV_WIDTH    = OCRA1_DIV_WIDTH,
  parameter int LDAC_CYCLES  = OCRA1_LDAC_CYCLES,
  parameter int SYNC_HIGH_HP = OCRA1_SYNC_HIGH_HP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] data_x_i,
  input  logic [FRAME_BITS-1:0] data_y_i,
  input  logic [FRAME_BITS-1:0] data_z_i,
  input  logic [FRAME_BITS-1:0] data_z2_i,
  input  logic                  valid_i,
  input  logic                  ldac_i,
  input  logic [DIV_WIDTH-1:0]  spi_div_i,
  input  logic                  overrun_clr_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  ocra1_clk_o,
  output logic                  ocra1_syncn_o,
  output logic                  ocra1_ldacn_o,
  output logic                  ocra1_sdox_o,
  output logic                  ocra1_sdoy_o,
  output logic                  ocra1_sdoz_o,
  output logic                  ocra1_sdoz2_o
);

  localparam int HP_W   = $clog2(2 * FRAME_BITS);
  localparam int LDAC_W = $clog2(LDAC_CYCLES + 1);
  localparam logic [HP_W-1:0]   SHIFT_LAST = HP_W'(2 * FRAME_BITS - 1);
  localparam logic [HP_W-1:0]   SYNC_LAST  = HP_W'(SYNC_HIGH_HP - 1);
  localparam logic [LDAC_W-1:0] LDAC_LAST  = LDAC_W'(LDAC_CYCLES - 1);

  ocra1_state_e                 state_q, state_d;
  ocra1_frame_set_t             pend_q;
  logic                         pend_full_q, pend_full_d;
  logic                         start, tick;
  logic [3:0][FRAME_BITS-1:0]   frame_words;
  logic [3:0][FRAME_BITS-1:0]   sr_q;
  logic [3:0]                   sdo_q;
  logic [HP_W-1:0]              hp_cnt_q;
  logic [LDAC_W-1:0]            ldac_cnt_q;
  logic                         ldac_q;
  logic                         sclk_q, syncn_q, ldacn_q, overrun_q, busy_q;

  ocra1_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .div_i   (spi_div_i),
    .tick_o  (tick)
  );

  // Index 0..3 = X, Y, Z, Z2 so one loop handles every channel.
  assign frame_words = {pend_q.z2, pend_q.z, pend_q.y, pend_q.x};

  // Every frame set, including one arriving while idle, goes through the
  // pending register; this gives the one-cycle start latency and makes a
  // start and a pop the same event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pend_full_q) state_d = SETUP;
      SETUP:     if (tick) state_d = SHIFT;
      SHIFT:     if (tick && hp_cnt_q == SHIFT_LAST) state_d = HOLD;
      HOLD:      if (tick) state_d = SYNC_HIGH;
      SYNC_HIGH: begin
        if (tick && hp_cnt_q == SYNC_LAST) begin
          if (ldac_q)           state_d = LDAC;
          else if (pend_full_q) state_d = SETUP;
          else                  state_d = IDLE;
        end
      end
      LDAC:      if (ldac_cnt_q == '0) state_d = pend_full_q ? SETUP : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign start       = (state_d == SETUP) && (state_q != SETUP);
  assign pend_full_d = valid_i | (pend_full_q & ~start);

  // State register; busy is registered from the next-cycle view so it rises
  // on the edge that captures valid_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE) | pend_full_d;
    end
  end

  // Pending buffer: a pop in the same cycle as valid_i frees the slot first,
  // so only an overwrite of a set that is not being started is an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pend_full_q <= pend_full_d;
      if (valid_i) begin
        pend_q <= {data_x_i, data_y_i, data_z_i, data_z2_i, ldac_i};
      end
      if (valid_i && pend_full_q && !start) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Pin sequencing. The MSB is put on the lines at frame start, SCLK first
  // rises without changing data, and every later rise (odd->even half-period
  // index) presents the next bit, so the DAC always samples stable data on
  // the fall. The shift registers hold only the bits not yet presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      sdo_q      <= '0;
      hp_cnt_q   <= '0;
      ldac_cnt_q <= '0;
      ldac_q     <= 1'b0;
      sclk_q     <= 1'b0;
      syncn_q    <= 1'b1;
      ldacn_q    <= 1'b1;
    end else if (start) begin
      for (int i = 0; i < 4; i++) begin
        sdo_q[i] <= frame_words[i][FRAME_BITS-1];
        sr_q[i]  <= {frame_words[i][FRAME_BITS-2:0], 1'b0};
      end
      ldac_q   <= pend_q.ldac;
      hp_cnt_q <= '0;
      sclk_q   <= 1'b0;
      syncn_q  <= 1'b0;
      ldacn_q  <= 1'b1;
    end else if (state_q == LDAC) begin
      if (ldac_cnt_q == '0) ldacn_q <= 1'b1;
      else                  ldac_cnt_q <= ldac_cnt_q - 1'b1;
    end else if (tick) begin
      case (state_q)
        SETUP: begin
          sclk_q   <= 1'b1;
          hp_cnt_q <= '0;
        end
        SHIFT: begin
          if (hp_cnt_q == SHIFT_LAST) begin
            sclk_q   <= 1'b0;
            hp_cnt_q <= '0;
          end else begin
            sclk_q   <= ~sclk_q;
            hp_cnt_q <= hp_cnt_q + 1'b1;
            if (hp_cnt_q[0]) begin
              for (int i = 0; i < 4; i++) begin
                sdo_q[i] <= sr_q[i][FRAME_BITS-1];
                sr_q[i]  <= {sr_q[i][FRAME_BITS-2:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          syncn_q  <= 1'b1;
          sdo_q    <= '0;
          hp_cnt_q <= '0;
        end
        SYNC_HIGH: begin
          if (hp_cnt_q == SYNC_LAST) begin
            hp_cnt_q <= '0;
            if (ldac_q) begin
              ldacn_q    <= 1'b0;
              ldac_cnt_q <= LDAC_LAST;
            end
          end else begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;
  assign ocra1_clk_o   = sclk_q;
  assign ocra1_syncn_o = syncn_q;
  assign ocra1_ldacn_o = ldacn_q;
  assign ocra1_sdox_o  = sdo_q[0];
  assign ocra1_sdoy_o  = sdo_q[1];
  assign ocra1_sdoz_o  = sdo_q[2];
  assign ocra1_sdoz2_o = sdo_q[3];

endmodule

// File: tb/tb_ocra1_spi_serialiser.sv
// ---------------------------------------------------------------------------
// tb_ocra1_spi_serialiser
// Directed bench for ocra1_spi_serialiser. Stimulus queues the frame sets it
// expects on the pins; a pin monitor rebuilds frames from SCLK falls and
// compares them against that queue, plus SYNCn/LDACn timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ocra1_spi_serialiser;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data_x_i, data_y_i, data_z_i, data_z2_i;
  logic        valid_i, ldac_i, overrun_clr_i;
  logic [5:0]  spi_div_i;
  logic        busy_o, overrun_o;
  logic        ocra1_clk_o, ocra1_syncn_o, ocra1_ldacn_o;
  logic        ocra1_sdox_o, ocra1_sdoy_o, ocra1_sdoz_o, ocra1_sdoz2_o;

  always #5 clk = ~clk;

  ocra1_spi_serialiser dut (
    .clk           (clk),
    .rst           (rst),
    .data_x_i      (data_x_i),
    .data_y_i      (data_y_i),
    .data_z_i      (data_z_i),
    .data_z2_i     (data_z2_i),
    .valid_i       (valid_i),
    .ldac_i        (ldac_i),
    .spi_div_i     (spi_div_i),
    .overrun_clr_i (overrun_clr_i),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o),
    .ocra1_clk_o   (ocra1_clk_o),
    .ocra1_syncn_o (ocra1_syncn_o),
    .ocra1_ldacn_o (ocra1_ldacn_o),
    .ocra1_sdox_o  (ocra1_sdox_o),
    .ocra1_sdoy_o  (ocra1_sdoy_o),
    .ocra1_sdoz_o  (ocra1_sdoz_o),
    .ocra1_sdoz2_o (ocra1_sdoz2_o)
  );

  typedef struct {
    logic [23:0] x, y, z, z2;
    logic        ldac;
    int          div;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   fail_cnt = 0;
  int   ldac_pulses = 0;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives a one-cycle valid_i strobe from a negedge and queues the frame set
  // expected on the pins; an overwriting set replaces the newest queue entry.
  task automatic applyStimulus(input logic [23:0] a_x, input logic [23:0] a_y,
                               input logic [23:0] a_z, input logic [23:0] a_z2,
                               input logic a_ldac, input logic [5:0] a_div,
                               input int exp_div, input logic clr,
                               input logic overwrite);
    exp_t e;
    e.x = a_x; e.y = a_y; e.z = a_z; e.z2 = a_z2; e.ldac = a_ldac; e.div = exp_div;
    if (overwrite) void'(sb_q.pop_back());
    sb_q.push_back(e);
    data_x_i = a_x; data_y_i = a_y; data_z_i = a_z; data_z2_i = a_z2;
    ldac_i = a_ldac; spi_div_i = a_div; overrun_clr_i = clr; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    overrun_clr_i = 1'b0;
  endtask

  task automatic pulseClear();
    overrun_clr_i = 1'b1;
    @(negedge clk);
    overrun_clr_i = 1'b0;
  endtask

  task automatic waitIdle(input int max_cycles, input string name);
    int n;
    n = 0;
    while (busy_o && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cycles) checkOutput({name, "_idle_timeout"}, 32'(busy_o), 0);
    repeat (3) @(negedge clk);
  endtask

  // Pin monitor state
  logic              prev_sclk, prev_syncn, prev_ldacn;
  logic [3:0]        prev_sdo;
  logic [3:0][23:0]  cap;
  int                falls, low_cnt, since_fall, spacing_ref, high_cnt;
  int                ldac_len, ldac_delay, last_div;
  logic              jitter_err, stab_err;

  // Rebuilds each frame from the SCLK falls inside SYNCn low, then compares
  // it with the oldest queued expectation when SYNCn rises.
  always @(negedge clk) begin
    logic [3:0] sdo_now;
    exp_t       e;
    sdo_now = {ocra1_sdoz2_o, ocra1_sdoz_o, ocra1_sdoy_o, ocra1_sdox_o};
    if (rst) begin
      falls = 0;
      ldac_len = 0;
      high_cnt = 0;
    end else begin
      if (prev_syncn && !ocra1_syncn_o) begin
        cap = '0; falls = 0; low_cnt = 0; since_fall = 0; spacing_ref = 0;
        jitter_err = 1'b0; stab_err = 1'b0;
      end
      if (!ocra1_syncn_o) begin
        low_cnt++;
        since_fall++;
        if (prev_sclk && !ocra1_clk_o) begin
          if (sdo_now != prev_sdo) stab_err = 1'b1;
          if (falls == 1) spacing_ref = since_fall;
          else if (falls > 1 && since_fall != spacing_ref) jitter_err = 1'b1;
          since_fall = 0;
          falls++;
          for (int i = 0; i < 4; i++) cap[i] = {cap[i][22:0], sdo_now[i]};
        end
      end
      if (!prev_syncn && ocra1_syncn_o) begin
        high_cnt = 0;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_frame", 0, 1);
        end else begin
          e = sb_q.pop_front();
          checkOutput("frame_x", 32'(cap[0]), 32'(e.x));
          checkOutput("frame_y", 32'(cap[1]), 32'(e.y));
          checkOutput("frame_z", 32'(cap[2]), 32'(e.z));
          checkOutput("frame_z2", 32'(cap[3]), 32'(e.z2));
          checkOutput("sclk_falls", falls, 24);
          checkOutput("syncn_low_cycles", low_cnt, 50 * (e.div + 1));
          checkOutput("sclk_period", spacing_ref, 2 * (e.div + 1));
          checkOutput("sclk_jitter", 32'(jitter_err), 0);
          checkOutput("sdo_stable_at_fall", 32'(stab_err), 0);
          last_div = e.div;
        end
      end else if (ocra1_syncn_o) begin
        high_cnt++;
      end
      if (!ocra1_ldacn_o) begin
        if (prev_ldacn) ldac_delay = high_cnt;
        ldac_len++;
      end else if (!prev_ldacn) begin
        checkOutput("ldac_len", ldac_len, 4);
        checkOutput("ldac_delay", ldac_delay, 2 * (last_div + 1));
        ldac_pulses++;
        ldac_len = 0;
      end
    end
    prev_sclk  = ocra1_clk_o;
    prev_syncn = ocra1_syncn_o;
    prev_ldacn = ocra1_ldacn_o;
    prev_sdo   = sdo_now;
  end

  // Guard against a hung DUT.
  initial begin
    repeat (40000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; valid_i = 1'b0; ldac_i = 1'b0; overrun_clr_i = 1'b0;
    spi_div_i = '0; data_x_i = '0; data_y_i = '0; data_z_i = '0; data_z2_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_clk", 32'(ocra1_clk_o), 0);
    checkOutput("reset_syncn", 32'(ocra1_syncn_o), 1);
    checkOutput("reset_ldacn", 32'(ocra1_ldacn_o), 1);
    checkOutput("reset_sdo", 32'({ocra1_sdoz2_o, ocra1_sdoz_o, ocra1_sdoy_o, ocra1_sdox_o}), 0);
    checkOutput("reset_busy", 32'(busy_o), 0);
    checkOutput("reset_overrun", 32'(overrun_o), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single X frame at div 0: start latency and busy tail.
    $display("[TB] div=0 single frame");
    applyStimulus(24'hA5F00F, 24'h0, 24'h0, 24'h0, 1'b0, 6'd0, 0, 1'b0, 1'b0);
    checkOutput("busy_after_valid", 32'(busy_o), 1);
    checkOutput("syncn_before_start", 32'(ocra1_syncn_o), 1);
    @(negedge clk);
    checkOutput("syncn_start_latency", 32'(ocra1_syncn_o), 0);
    checkOutput("sdox_msb_at_start", 32'(ocra1_sdox_o), 1);
    n = 0;
    while (!ocra1_syncn_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) checkOutput("syncn_rise_timeout", 32'(ocra1_syncn_o), 1);
    n = 0;
    while (busy_o && n < 20) begin @(negedge clk); n++; end
    checkOutput("busy_drop_after_syncn", n, 2);
    waitIdle(100, "t1");

    // All four channels at div 3 with LDAC.
    $display("[TB] div=3 four channels with ldac");
    applyStimulus(24'h123456, 24'h789ABC, 24'hFEDCBA, 24'h0F1E2D, 1'b1, 6'd3, 3, 1'b0, 1'b0);
    waitIdle(400, "t2");

    // Three strobes 5 cycles apart: the third overwrites the second.
    $display("[TB] overwrite of pending set");
    applyStimulus(24'h111111, 24'h222222, 24'h333333, 24'h444444, 1'b0, 6'd0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD, 1'b0, 6'd0, 0, 1'b0, 1'b0);
    checkOutput("overrun_after_store", 32'(overrun_o), 0);
    repeat (4) @(negedge clk);
    applyStimulus(24'h5A5A5A, 24'hC3C3C3, 24'h0F0F0F, 24'hF0F0F0, 1'b0, 6'd0, 0, 1'b0, 1'b1);
    checkOutput("overrun_after_overwrite", 32'(overrun_o), 1);
    waitIdle(300, "t3");

    // Clear behaviour: a lone clear wins, a simultaneous overrun wins over clear.
    $display("[TB] overrun clear");
    checkOutput("overrun_sticky", 32'(overrun_o), 1);
    pulseClear();
    checkOutput("overrun_lone_clear", 32'(overrun_o), 0);
    applyStimulus(24'h000001, 24'h800000, 24'h7FFFFF, 24'hFFFFFE, 1'b0, 6'd0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h00000F, 1'b0, 6'd0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(24'hC0FFEE, 24'hBADBAD, 24'h13579B, 24'h2468AC, 1'b0, 6'd0, 0, 1'b1, 1'b1);
    checkOutput("overrun_set_beats_clear", 32'(overrun_o), 1);
    pulseClear();
    checkOutput("overrun_clear_again", 32'(overrun_o), 0);
    waitIdle(300, "t4");

    // Divider changed mid-frame only affects the following frame set.
    $display("[TB] divider change mid-frame");
    applyStimulus(24'h0C0C0C, 24'h3F3F3F, 24'h9E9E9E, 24'h010203, 1'b0, 6'd0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(24'hE1E2E3, 24'h445566, 24'h778899, 24'hAABBCC, 1'b0, 6'd0, 5, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    spi_div_i = 6'd5;
    waitIdle(800, "t5");

    // Reset around bit 10 of a div 1 frame aborts it cleanly.
    $display("[TB] reset mid-frame");
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 6'd1, 1, 1'b0, 1'b0);
    repeat (44) @(negedge clk);
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_clk", 32'(ocra1_clk_o), 0);
    checkOutput("midrst_syncn", 32'(ocra1_syncn_o), 1);
    checkOutput("midrst_ldacn", 32'(ocra1_ldacn_o), 1);
    checkOutput("midrst_sdo", 32'({ocra1_sdoz2_o, ocra1_sdoz_o, ocra1_sdoy_o, ocra1_sdox_o}), 0);
    checkOutput("midrst_busy", 32'(busy_o), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(24'h3C3C3C, 24'h96A5B4, 24'h000000, 24'hFFFFFF, 1'b1, 6'd1, 1, 1'b0, 1'b0);
    waitIdle(400, "t6");

    checkOutput("queue_drained", sb_q.size(), 0);
    checkOutput("ldac_pulse_count", ldac_pulses, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
